// File: rtl/powlib_ipsaxi_wrarb.sv
// powlib_ipsaxi_wrarb
// Round-robin arbiter that shares one AXI write slave port between NM AXI
// write masters. A grant covers one whole burst: a single AW beat plus W beats
// up to wlast. The forwarded AWID carries the master index in its upper MIW
// bits, and B responses are steered back by that tag.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   m_aw*  / m_awvalid       packed master AW channels (master k in slice k)
//   m_awready                per-master AW ready
//   m_w*   / m_wvalid        packed master W channels
//   m_wready                 per-master W ready
//   m_bid, m_bresp           B payload broadcast to all masters
//   m_bvalid / m_bready      per-master B handshake
//   s_aw*, s_awvalid/ready   AW channel toward the slave (s_awid = {tag, id})
//   s_w*,  s_wvalid/ready    W channel toward the slave
//   s_bid, s_bresp, s_bvalid/s_bready  B channel from the slave

`ifndef POWLIB_BW
`define POWLIB_BW 8
`endif
`ifndef AXI_LENW
`define AXI_LENW 8
`endif
`ifndef AXI_SIZEW
`define AXI_SIZEW 3
`endif
`ifndef AXI_BURSTW
`define AXI_BURSTW 2
`endif
`ifndef AXI_RESPW
`define AXI_RESPW 2
`endif

module powlib_ipsaxi_wrarb #(
  parameter int  NM    = 2,
  parameter int  IDW   = 1,
  parameter int  B_BPD = 4,
  parameter int  B_AW  = `POWLIB_BW*B_BPD,
  localparam int MIW   = (NM > 1) ? $clog2(NM) : 1,
  localparam int SIW   = IDW + MIW,
  localparam int B_DW  = `POWLIB_BW*B_BPD,
  localparam int B_BEW = B_BPD
) (
  input  logic                        clk,
  input  logic                        rst,
  // master side AW
  input  logic [NM*IDW-1:0]           m_awid,
  input  logic [NM*B_AW-1:0]          m_awaddr,
  input  logic [NM*`AXI_LENW-1:0]     m_awlen,
  input  logic [NM*`AXI_SIZEW-1:0]    m_awsize,
  input  logic [NM*`AXI_BURSTW-1:0]   m_awburst,
  input  logic [NM-1:0]               m_awvalid,
  output logic [NM-1:0]               m_awready,
  // master side W
  input  logic [NM*B_DW-1:0]          m_wdata,
  input  logic [NM*B_BEW-1:0]         m_wstrb,
  input  logic [NM-1:0]               m_wlast,
  input  logic [NM-1:0]               m_wvalid,
  output logic [NM-1:0]               m_wready,
  // master side B
  output logic [IDW-1:0]              m_bid,
  output logic [`AXI_RESPW-1:0]       m_bresp,
  output logic [NM-1:0]               m_bvalid,
  input  logic [NM-1:0]               m_bready,
  // slave side AW
  output logic [SIW-1:0]              s_awid,
  output logic [B_AW-1:0]             s_awaddr,
  output logic [`AXI_LENW-1:0]        s_awlen,
  output logic [`AXI_SIZEW-1:0]       s_awsize,
  output logic [`AXI_BURSTW-1:0]      s_awburst,
  output logic                        s_awvalid,
  input  logic                        s_awready,
  // slave side W
  output logic [B_DW-1:0]             s_wdata,
  output logic [B_BEW-1:0]            s_wstrb,
  output logic                        s_wlast,
  output logic                        s_wvalid,
  input  logic                        s_wready,
  // slave side B
  input  logic [SIW-1:0]              s_bid,
  input  logic [`AXI_RESPW-1:0]       s_bresp,
  input  logic                        s_bvalid,
  output logic                        s_bready
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t         state_reg;
  logic [MIW-1:0] gnt_reg;
  logic [MIW-1:0] last_reg;
  logic           aw_done_reg;
  logic           w_done_reg;

  // per-master views of the packed buses
  logic [IDW-1:0]         awid_a    [NM];
  logic [B_AW-1:0]        awaddr_a  [NM];
  logic [`AXI_LENW-1:0]   awlen_a   [NM];
  logic [`AXI_SIZEW-1:0]  awsize_a  [NM];
  logic [`AXI_BURSTW-1:0] awburst_a [NM];
  logic [B_DW-1:0]        wdata_a   [NM];
  logic [B_BEW-1:0]       wstrb_a   [NM];

  for (genvar gi = 0; gi < NM; gi++) begin : g_unpack
    assign awid_a[gi]    = m_awid[gi*IDW +: IDW];
    assign awaddr_a[gi]  = m_awaddr[gi*B_AW +: B_AW];
    assign awlen_a[gi]   = m_awlen[gi*`AXI_LENW +: `AXI_LENW];
    assign awsize_a[gi]  = m_awsize[gi*`AXI_SIZEW +: `AXI_SIZEW];
    assign awburst_a[gi] = m_awburst[gi*`AXI_BURSTW +: `AXI_BURSTW];
    assign wdata_a[gi]   = m_wdata[gi*B_DW +: B_DW];
    assign wstrb_a[gi]   = m_wstrb[gi*B_BEW +: B_BEW];
  end

  logic in_xfer;
  assign in_xfer = (state_reg == XFER);

  // Payloads follow the grant unconditionally; only valid/ready are gated.
  assign s_awid    = {gnt_reg, awid_a[gnt_reg]};
  assign s_awaddr  = awaddr_a[gnt_reg];
  assign s_awlen   = awlen_a[gnt_reg];
  assign s_awsize  = awsize_a[gnt_reg];
  assign s_awburst = awburst_a[gnt_reg];
  assign s_wdata   = wdata_a[gnt_reg];
  assign s_wstrb   = wstrb_a[gnt_reg];
  assign s_wlast   = m_wlast[gnt_reg];

  // W is never held behind AW: the slave wants write data before taking AW.
  assign s_awvalid = in_xfer && m_awvalid[gnt_reg] && !aw_done_reg;
  assign s_wvalid  = in_xfer && m_wvalid[gnt_reg] && !w_done_reg;

  always_comb begin
    m_awready = '0;
    m_wready  = '0;
    if (in_xfer) begin
      m_awready[gnt_reg] = s_awready && !aw_done_reg;
      m_wready[gnt_reg]  = s_wready && !w_done_reg;
    end
  end

  logic aw_hs;
  logic wlast_hs;
  assign aw_hs    = s_awvalid && s_awready;
  assign wlast_hs = s_wvalid && s_wready && s_wlast;

  // Round-robin pick: first requester after last_reg. Scanning downward lets
  // the nearest candidate overwrite farther ones.
  logic [MIW-1:0] pick;
  always_comb begin
    pick = '0;
    for (int i = NM; i >= 1; i--) begin
      if (m_awvalid[(int'(last_reg) + i) % NM]) begin
        pick = MIW'((int'(last_reg) + i) % NM);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      gnt_reg     <= '0;
      last_reg    <= MIW'(NM-1);
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|m_awvalid) begin
            gnt_reg     <= pick;
            last_reg    <= pick;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            state_reg   <= XFER;
          end
        end
        XFER: begin
          if (aw_hs)    aw_done_reg <= 1'b1;
          if (wlast_hs) w_done_reg  <= 1'b1;
          // both halves may complete on the same edge
          if ((aw_done_reg || aw_hs) && (w_done_reg || wlast_hs)) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // B routing is purely combinational and independent of the write grant.
  // A tag with no matching master is acknowledged and dropped.
  logic [MIW-1:0] b_tag;
  assign b_tag   = s_bid[SIW-1 -: MIW];
  assign m_bid   = s_bid[IDW-1:0];
  assign m_bresp = s_bresp;

  always_comb begin
    m_bvalid = '0;
    s_bready = 1'b1;
    for (int i = 0; i < NM; i++) begin
      if (b_tag == MIW'(i)) begin
        m_bvalid[i] = s_bvalid;
        s_bready    = m_bready[i];
      end
    end
  end

endmodule

// File: doc/powlib_ipsaxi_wrarb.md
Name: powlib_ipsaxi_wrarb

Overview:
- Round-robin arbiter that shares one AXI write slave port (the PLB-bridging AXI write slave) between NM AXI write masters.
- Grants one master at a time for a complete burst: one AW beat plus its W beats up to wlast.
- Tags the forwarded AWID with the master index and routes B responses back by that tag.
- Sits between the interconnect's master-side ports and the single AXI write slave.

Parameters:
- NM, 2, number of requesting masters (2..16).
- IDW, 1, per-master AXI ID width.
- B_BPD, 4, bytes per data beat.
- B_AW, `POWLIB_BW*B_BPD, address width.
- MIW (local), max(1,ceil(log2(NM))), master-index tag width.
- SIW (local), IDW+MIW, slave-side ID width; tag occupies the upper MIW bits.
- B_DW (local), `POWLIB_BW*B_BPD, data width.
- B_BEW (local), B_BPD, strobe width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- m_awid/m_awaddr/m_awlen/m_awsize/m_awburst  in  NM*(IDW / B_AW / `AXI_LENW / `AXI_SIZEW / `AXI_BURSTW)  packed master AW fields; master k in slice k.
- m_awvalid  in  NM  per-master AW valid.
- m_awready  out  NM  per-master AW ready.
- m_wdata/m_wstrb/m_wlast  in  NM*(B_DW / B_BEW / 1)  packed master W fields.
- m_wvalid  in  NM  per-master W valid.
- m_wready  out  NM  per-master W ready.
- m_bid/m_bresp  out  IDW / `AXI_RESPW  broadcast B fields.
- m_bvalid  out  NM  per-master B valid.
- m_bready  in  NM  per-master B ready.
- s_awid  out  SIW  {gnt index, m_awid[gnt]}.
- s_awaddr/s_awlen/s_awsize/s_awburst  out  as AXI  forwarded AW fields.
- s_awvalid  out  1  AW valid to slave.
- s_awready  in  1  AW ready from slave.
- s_wdata/s_wstrb/s_wlast  out  B_DW/B_BEW/1  forwarded W fields.
- s_wvalid  out  1  W valid to slave.
- s_wready  in  1  W ready from slave.
- s_bid/s_bresp  in  SIW/`AXI_RESPW  B response from slave.
- s_bvalid  in  1  B valid from slave.
- s_bready  out  1  B ready to slave.

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE, gnt=0, last=NM-1, aw_done=w_done=0. All m_awready, m_wready, s_awvalid and s_wvalid are 0 from the next edge. B path is combinational, so it is effectively idle as well. Reset mid-burst abandons the burst; the slave must be reset in the same cycle.
- FSM IDLE:
  - If any m_awvalid is set, pick the first requester searching (last+1)..(last+NM) mod NM.
  - Register gnt=last=that index; clear aw_done and w_done; go to XFER.
  - Adds 1 cycle of arbitration latency.
  - No forwarding occurs in IDLE.
- FSM XFER, AW forwarding (combinational from gnt):
  - s_aw* = master gnt's fields.
  - s_awvalid = m_awvalid[gnt] && !aw_done.
  - m_awready[gnt] = s_awready && !aw_done.
  - AW handshake sets aw_done.
- FSM XFER, W forwarding:
  - s_w* = master gnt's fields.
  - s_wvalid = m_wvalid[gnt] && !w_done.
  - m_wready[gnt] = s_wready && !w_done.
  - A W handshake with wlast=1 sets w_done.
  - W is forwarded concurrently with AW, never gated behind it; the slave needs W data present before it accepts AW.
- Non-granted masters: m_awready=m_wready=0 at all times.
- XFER→IDLE: when (aw_done || AW handshake this cycle) && (w_done || wlast handshake this cycle). Same-cycle completion of both is legal and exits directly. Back-to-back grants therefore have a 1-cycle IDLE gap.
- Burst length: wlast is the only W terminator; beats are not counted against awlen. Length mismatches are reported by the slave as SLVERR and passed through.
- B routing (combinational, independent of FSM):
  - tag = s_bid[SIW-1 -: MIW].
  - m_bvalid[tag] = s_bvalid; m_bvalid is 0 for all other masters.
  - m_bid = s_bid[IDW-1:0]; m_bresp = s_bresp.
  - s_bready = m_bready[tag].
  - A tag >= NM drops the response: s_bready=1, no m_bvalid.
- Fairness: a master continuously requesting waits at most NM-1 bursts.
- AXI rule: every output valid, once asserted, holds with stable payload until its handshake. Grant never changes inside XFER.

Test Plan:
- NM=2, only m1 issues AW(addr=0x100,len=3) plus 4 W beats → s_awid={1,id}; 4 beats pass in order; s_wlast on beat 4; FSM returns to IDLE the cycle after the last handshake.
- Both masters request continuously, each len=0 → grants alternate 0,1,0,1 starting with m0 after reset; 1 idle cycle between bursts.
- m0 presents W beats 3 cycles before AW; slave holds s_awready=0 until W valid → W is forwarded first, no deadlock, aw_done is set later, then exit.
- Slave returns B with s_bid={1,0}, bresp=SLVERR, and m1 bready=0 for 2 cycles → m_bvalid=2'b10 held; s_bready=0 until m1 bready=1; m0 never sees bvalid.
- AW handshake and wlast handshake in the same cycle (len=0) → exit to IDLE in 1 cycle; next grant follows round-robin.
- rst=0 for 1 cycle mid-burst (beat 2 of 4) → next cycle all ready/valid outputs=0, state IDLE, m0 has highest priority again.
